mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 16:1 bit mux (mux_s). Up to N requesters

---
 rtl/mux_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 16:1 bit mux: picks one requester,
// drives the mux select and one-hot grant, and rotates after MAX_BURST accepted beats.
module mux_rr_arbiter #(
    parameter int N         = 16,
    parameter int SEL_W     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     gnt,
    output logic             out_valid,
    output logic [N-1:0]     ack,
    output logic             busy
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic             cur_req;
    logic             beat;
    logic             rel;
    logic [SEL_W-1:0] next_ptr;
    logic [N-1:0]     req_masked;
    logic [SEL_W:0]   idle_win;
    logic [SEL_W:0]   rel_win;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod N.
    function automatic logic [SEL_W:0] pick(input logic [N-1:0] r, input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        cur_req    = req[sel];
        beat       = out_ready & cur_req;
        rel        = ~cur_req | (beat & (cnt == CNT_W'(MAX_BURST - 1)));
        next_ptr   = sel + 1'b1;
        req_masked = req & ~onehot(sel);
        idle_win   = pick(req, ptr);
        rel_win    = pick(req_masked, next_ptr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (idle_win[SEL_W]) begin
                        state     <= GRANT;
                        sel       <= idle_win[SEL_W-1:0];
                        gnt       <= onehot(idle_win[SEL_W-1:0]);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr <= next_ptr;
                        cnt <= '0;
                        // Other requesters take precedence; the current owner only keeps the bus if alone.
                        if (rel_win[SEL_W]) begin
                            sel <= rel_win[SEL_W-1:0];
                            gnt <= onehot(rel_win[SEL_W-1:0]);
                        end else if (!cur_req) begin
                            state     <= IDLE;
                            sel       <= '0;
                            gnt       <= '0;
                            out_valid <= 1'b0;
                        end
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ack  = gnt & {N{out_valid & out_ready & req[sel]}};
    assign busy = out_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table, directed corner sequences and a
// randomized run against an owner/pointer reference model.
module tb_mux_rr_arbiter;
    localparam int N  = 16;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        out_ready;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        out_valid;
    logic [15:0] ack;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mux_rr_arbiter #(.N(N), .SEL_W(4), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .sel(sel), .gnt(gnt), .out_valid(out_valid), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic [15:0] rq;
        logic        rdy;
        logic [3:0]  esel;
        logic [15:0] egnt;
        logic        ev;
        logic [15:0] eack;
    } vec_t;

    vec_t vt[16];

    // Reference model: who owns the bus, rotation pointer, beats taken.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic apply(input logic rn, input logic [15:0] rq, input logic rdy);
        @(negedge clk);
        rst_n     = rn;
        req       = rq;
        out_ready = rdy;
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] es, input logic [15:0] eg,
                         input logic ev, input logic [15:0] ea);
        checks++;
        if (sel !== es || gnt !== eg || out_valid !== ev || ack !== ea || busy !== ev) begin
            errors++;
            $display("FAIL %s: got sel=%0d gnt=%h valid=%b ack=%h busy=%b, expected sel=%0d gnt=%h valid=%b ack=%h",
                     nm, sel, gnt, out_valid, ack, busy, es, eg, ev, ea);
        end
    endtask

    function automatic int scan(input logic [15:0] r, input int p, input int skip);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_check(input string nm);
        logic [15:0] eg;
        logic [15:0] ea;
        eg = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        ea = (m_owner >= 0 && out_ready && req[m_owner]) ? eg : 16'h0;
        check(nm, (m_owner >= 0) ? 4'(m_owner) : 4'd0, eg, m_owner >= 0, ea);
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            w = scan(req, m_ptr, -1);
            if (w >= 0) begin m_owner = w; m_cnt = 0; end
        end else if (!req[m_owner] || (out_ready && m_cnt == MB - 1)) begin
            m_ptr = (m_owner + 1) % N;
            w     = scan(req, m_ptr, m_owner);
            m_cnt = 0;
            if (w >= 0)                m_owner = w;
            else if (!req[m_owner])    m_owner = -1;
        end else if (out_ready) begin
            m_cnt++;
        end
    endtask

    task automatic do_reset();
        apply(1'b0, 16'h0, 1'b0);
        apply(1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0;

        vt[0]  = '{1, 16'h0020, 1, 4'd0, 16'h0000, 0, 16'h0000};
        vt[1]  = '{1, 16'h0020, 1, 4'd5, 16'h0020, 1, 16'h0020};
        vt[2]  = '{1, 16'h0020, 1, 4'd5, 16'h0020, 1, 16'h0020};
        vt[3]  = '{1, 16'h0020, 1, 4'd5, 16'h0020, 1, 16'h0020};
        vt[4]  = '{1, 16'h0020, 1, 4'd5, 16'h0020, 1, 16'h0020};
        vt[5]  = '{1, 16'h0020, 1, 4'd5, 16'h0020, 1, 16'h0020};
        vt[6]  = '{1, 16'h0020, 0, 4'd5, 16'h0020, 1, 16'h0000};
        vt[7]  = '{1, 16'h0200, 1, 4'd5, 16'h0020, 1, 16'h0000};
        vt[8]  = '{1, 16'h0200, 1, 4'd9, 16'h0200, 1, 16'h0200};
        vt[9]  = '{1, 16'h0000, 1, 4'd9, 16'h0200, 1, 16'h0000};
        vt[10] = '{1, 16'h0000, 1, 4'd0, 16'h0000, 0, 16'h0000};
        vt[11] = '{1, 16'h0080, 1, 4'd0, 16'h0000, 0, 16'h0000};
        vt[12] = '{0, 16'h0084, 1, 4'd7, 16'h0080, 1, 16'h0080};
        vt[13] = '{1, 16'h0084, 1, 4'd0, 16'h0000, 0, 16'h0000};
        vt[14] = '{1, 16'h0084, 1, 4'd2, 16'h0004, 1, 16'h0004};
        vt[15] = '{1, 16'h0084, 1, 4'd2, 16'h0004, 1, 16'h0004};

        do_reset();
        check("reset", 4'd0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            apply(vt[i].rn, vt[i].rq, vt[i].rdy);
            check($sformatf("vec%0d", i), vt[i].esel, vt[i].egnt, vt[i].ev, vt[i].eack);
        end

        // Stall for 10 cycles on requester 3, then 4 beats and rotation to 4.
        do_reset();
        apply(1'b1, 16'h0008, 1'b0);
        check("stall_idle", 4'd0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 16'h0018, 1'b0);
            check($sformatf("stall%0d", i), 4'd3, 16'h0008, 1'b1, 16'h0);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 16'h0018, 1'b1);
            check($sformatf("stall_beat%0d", i), 4'd3, 16'h0008, 1'b1, 16'h0008);
        end
        apply(1'b1, 16'h0018, 1'b1);
        check("stall_rotate", 4'd4, 16'h0010, 1'b1, 16'h0010);

        // All requesting: each index gets 4 beats in turn, wrapping 15->0.
        do_reset();
        apply(1'b1, 16'hFFFF, 1'b1);
        check("all_idle", 4'd0, 16'h0, 1'b0, 16'h0);
        for (int k = 0; k < 68; k++) begin
            logic [3:0] s;
            s = 4'((k / MB) % N);
            apply(1'b1, 16'hFFFF, 1'b1);
            check($sformatf("all%0d", k), s, 16'h1 << s, 1'b1, 16'h1 << s);
        end

        // Pair 0/15 alternating with wrap.
        do_reset();
        apply(1'b1, 16'h8001, 1'b1);
        check("pair_idle", 4'd0, 16'h0, 1'b0, 16'h0);
        for (int k = 0; k < 24; k++) begin
            logic [3:0] s;
            s = ((k / MB) % 2 == 0) ? 4'd0 : 4'd15;
            apply(1'b1, 16'h8001, 1'b1);
            check($sformatf("pair%0d", k), s, 16'h1 << s, 1'b1, 16'h1 << s);
        end

        // Randomized run against the reference model.
        apply(1'b0, 16'h0, 1'b0);
        model_step();
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] rq;
            logic        rn;
            rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 16'h0;
            rn = ($urandom_range(0, 150) != 0);
            apply(rn, rq, $urandom_range(0, 3) != 0);
            model_check($sformatf("rand%0d", c));
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
